// File: rtl/writeback_stage_reg.sv
// MEM/WB writeback stage: N-source result select, load byte/half extraction with
// sign/zero extension, and registered register-file write port / forwarding outputs.
module writeback_stage_reg #(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SRC        = 4,
    parameter int MEM_SRC_IDX    = 1,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int SEL_WIDTH      = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          In_Valid,
    input  logic                          Stall,
    input  logic                          Flush,
    input  logic                          RegWrite,
    input  logic [SEL_WIDTH-1:0]          WbSel,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] Src_Data,
    input  logic [1:0]                    Load_Size,
    input  logic                          Load_Unsigned,
    input  logic [$clog2(DATA_WIDTH/8)-1:0] Byte_Offset,
    input  logic [REG_ADDR_WIDTH-1:0]     Dest_Reg,
    output logic [DATA_WIDTH-1:0]         Write_Data_Output,
    output logic [REG_ADDR_WIDTH-1:0]     Write_Reg,
    output logic                          Reg_Write_En,
    output logic                          Wb_Valid,
    output logic                          Align_Error,
    output logic                          Sel_Error
);

    localparam int OFF_W = $clog2(DATA_WIDTH/8);

    logic [DATA_WIDTH-1:0]     r_data;
    logic [REG_ADDR_WIDTH-1:0] r_reg;
    logic                      r_we;
    logic                      r_valid;
    logic                      r_align_err;
    logic                      r_sel_err;

    logic [SEL_WIDTH:0]    w_sel_ext;
    logic                  w_sel_oob;
    logic                  w_is_mem;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic [OFF_W-1:0]      w_half_off;
    logic [DATA_WIDTH-1:0] w_byte_shift;
    logic [DATA_WIDTH-1:0] w_half_shift;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [DATA_WIDTH-1:0] w_result;
    logic                  w_align_err;
    logic                  w_sel_err;
    logic                  w_we;

    // One extra select bit keeps the range check meaningful when 2**SEL_WIDTH == NUM_SRC.
    assign w_sel_ext = {1'b0, WbSel};
    assign w_sel_oob = (w_sel_ext >= (SEL_WIDTH+1)'(NUM_SRC));
    assign w_is_mem  = (w_sel_ext == (SEL_WIDTH+1)'(MEM_SRC_IDX));

    always_comb begin
        w_sel_data = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (32'(w_sel_ext) == i) begin
                w_sel_data = Src_Data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Half-word lane pair is the offset with its low bit cleared.
    assign w_half_off   = Byte_Offset & ~(OFF_W'(1));
    assign w_byte_shift = w_sel_data >> {Byte_Offset, 3'b000};
    assign w_half_shift = w_sel_data >> {w_half_off, 3'b000};
    assign w_byte       = w_byte_shift[7:0];
    assign w_half       = w_half_shift[15:0];

    always_comb begin
        w_result = w_sel_data;
        if (w_is_mem) begin
            case (Load_Size)
                2'b00:   w_result = {{(DATA_WIDTH-8){~Load_Unsigned & w_byte[7]}}, w_byte};
                2'b01:   w_result = {{(DATA_WIDTH-16){~Load_Unsigned & w_half[15]}}, w_half};
                default: w_result = w_sel_data;
            endcase
        end
    end

    assign w_align_err = In_Valid & w_is_mem &
                         (((Load_Size == 2'b01) & Byte_Offset[0]) |
                          (Load_Size[1] & (Byte_Offset != '0)));
    assign w_sel_err   = In_Valid & w_sel_oob;
    assign w_we        = In_Valid & RegWrite & (Dest_Reg != '0) & ~w_align_err & ~w_sel_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data      <= '0;
            r_reg       <= '0;
            r_we        <= 1'b0;
            r_valid     <= 1'b0;
            r_align_err <= 1'b0;
            r_sel_err   <= 1'b0;
        end else if (Flush) begin
            r_we        <= 1'b0;
            r_valid     <= 1'b0;
            r_align_err <= 1'b0;
            r_sel_err   <= 1'b0;
        end else if (!Stall) begin
            r_data      <= w_result;
            r_reg       <= Dest_Reg;
            r_we        <= w_we;
            r_valid     <= In_Valid;
            r_align_err <= w_align_err;
            r_sel_err   <= w_sel_err;
        end
    end

    assign Write_Data_Output = r_data;
    assign Write_Reg         = r_reg;
    assign Reg_Write_En      = r_we;
    assign Wb_Valid          = r_valid;
    assign Align_Error       = r_align_err;
    assign Sel_Error         = r_sel_err;

endmodule

// File: tb/tb_writeback_stage_reg.sv
// Directed bench for writeback_stage_reg: default build, a 3-source build
// for out-of-range select, and a 64-bit build for wide load extraction.
module tb_writeback_stage_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        In_Valid, Stall, Flush, RegWrite;
    logic [1:0]  Load_Size;
    logic        Load_Unsigned;
    logic [4:0]  Dest_Reg;

    logic [1:0]   wb0;
    logic [127:0] src0;
    logic [1:0]   off0;
    logic [31:0]  data0;
    logic [4:0]   reg0;
    logic         we0, vld0, aerr0, serr0;

    logic [1:0]  wb1;
    logic [95:0] src1;
    logic [1:0]  off1;
    logic [31:0] data1;
    logic [4:0]  reg1;
    logic        we1, vld1, aerr1, serr1;

    logic [1:0]   wb2;
    logic [255:0] src2;
    logic [2:0]   off2;
    logic [63:0]  data2;
    logic [4:0]   reg2;
    logic         we2, vld2, aerr2, serr2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    writeback_stage_reg dut0 (
        .clk(clk), .reset(reset), .In_Valid(In_Valid), .Stall(Stall), .Flush(Flush),
        .RegWrite(RegWrite), .WbSel(wb0), .Src_Data(src0), .Load_Size(Load_Size),
        .Load_Unsigned(Load_Unsigned), .Byte_Offset(off0), .Dest_Reg(Dest_Reg),
        .Write_Data_Output(data0), .Write_Reg(reg0), .Reg_Write_En(we0),
        .Wb_Valid(vld0), .Align_Error(aerr0), .Sel_Error(serr0)
    );

    writeback_stage_reg #(.NUM_SRC(3)) dut1 (
        .clk(clk), .reset(reset), .In_Valid(In_Valid), .Stall(Stall), .Flush(Flush),
        .RegWrite(RegWrite), .WbSel(wb1), .Src_Data(src1), .Load_Size(Load_Size),
        .Load_Unsigned(Load_Unsigned), .Byte_Offset(off1), .Dest_Reg(Dest_Reg),
        .Write_Data_Output(data1), .Write_Reg(reg1), .Reg_Write_En(we1),
        .Wb_Valid(vld1), .Align_Error(aerr1), .Sel_Error(serr1)
    );

    writeback_stage_reg #(.DATA_WIDTH(64)) dut2 (
        .clk(clk), .reset(reset), .In_Valid(In_Valid), .Stall(Stall), .Flush(Flush),
        .RegWrite(RegWrite), .WbSel(wb2), .Src_Data(src2), .Load_Size(Load_Size),
        .Load_Unsigned(Load_Unsigned), .Byte_Offset(off2), .Dest_Reg(Dest_Reg),
        .Write_Data_Output(data2), .Write_Reg(reg2), .Reg_Write_En(we2),
        .Wb_Valid(vld2), .Align_Error(aerr2), .Sel_Error(serr2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk0(input string tag, input logic [31:0] d, input logic [4:0] r,
                        input logic we, input logic v, input logic ae, input logic se);
        chk({tag, ".data"},  64'(data0), 64'(d));
        chk({tag, ".reg"},   64'(reg0),  64'(r));
        chk({tag, ".we"},    64'(we0),   64'(we));
        chk({tag, ".valid"}, 64'(vld0),  64'(v));
        chk({tag, ".aerr"},  64'(aerr0), 64'(ae));
        chk({tag, ".serr"},  64'(serr0), 64'(se));
    endtask

    initial begin
        reset = 1'b1; In_Valid = 1'b1; RegWrite = 1'b1; Stall = 1'b0; Flush = 1'b0;
        Load_Size = 2'b10; Load_Unsigned = 1'b0; Dest_Reg = 5'd5;
        wb0 = 2'd0; off0 = 2'd0;
        src0 = {32'h0000_1000, 32'h0000_0044, 32'hAABB_CCDD, 32'h0000_0007};
        wb1 = 2'd0; off1 = 2'd0;
        src1 = {32'h0000_0044, 32'hAABB_CCDD, 32'h0000_0007};
        wb2 = 2'd0; off2 = 3'd0;
        src2 = {64'h0, 64'h0, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0009};

        // Reset overrides a valid writing instruction
        tick();
        chk0("reset", 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.d1", 64'(data1), 64'h0);
        chk("reset.v2", 64'(vld2), 64'h0);

        // Source select sweep
        reset = 1'b0;
        wb0 = 2'd0; tick(); chk0("sel_alu", 32'h0000_0007, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        wb0 = 2'd1; tick(); chk0("sel_mem", 32'hAABB_CCDD, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        wb0 = 2'd2; tick(); chk0("sel_pc4", 32'h0000_0044, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        wb0 = 2'd3; tick(); chk0("sel_imm", 32'h0000_1000, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);

        // Load extraction
        src0[63:32] = 32'h80FF_7F01; wb0 = 2'd1; Dest_Reg = 5'd7;
        Load_Size = 2'b00; Load_Unsigned = 1'b0; off0 = 2'd2; tick();
        chk0("lb_s_o2", 32'hFFFF_FFFF, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        Load_Unsigned = 1'b1; off0 = 2'd3; tick();
        chk0("lb_u_o3", 32'h0000_0080, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        Load_Unsigned = 1'b0; off0 = 2'd1; tick();
        chk0("lb_s_o1", 32'h0000_007F, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        Load_Size = 2'b01; off0 = 2'd0; tick();
        chk0("lh_s_o0", 32'h0000_7F01, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        off0 = 2'd2; tick();
        chk0("lh_s_o2", 32'hFFFF_80FF, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        Load_Unsigned = 1'b1; tick();
        chk0("lh_u_o2", 32'h0000_80FF, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        Load_Unsigned = 1'b0; off0 = 2'd1; tick();
        chk("lh_o1.aerr", 64'(aerr0), 64'h1);
        chk("lh_o1.we",   64'(we0),   64'h0);
        chk("lh_o1.valid", 64'(vld0), 64'h1);
        Load_Size = 2'b10; off0 = 2'd2; tick();
        chk("lw_o2.aerr", 64'(aerr0), 64'h1);
        chk("lw_o2.we",   64'(we0),   64'h0);
        off0 = 2'd0; tick();
        chk0("lw_o0", 32'h80FF_7F01, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        // Non-mem source ignores misaligned offset
        wb0 = 2'd2; Load_Size = 2'b01; off0 = 2'd1; tick();
        chk0("pc4_off1", 32'h0000_0044, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);

        // Stall holds for three cycles
        wb0 = 2'd0; Dest_Reg = 5'd5; Load_Size = 2'b10; off0 = 2'd0; tick();
        chk0("pre_stall", 32'h0000_0007, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        Stall = 1'b1; wb0 = 2'd2; Dest_Reg = 5'd9;
        tick(); chk0("stall1", 32'h0000_0007, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(); chk0("stall2", 32'h0000_0007, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(); chk0("stall3", 32'h0000_0007, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        Flush = 1'b1; tick();
        chk("flush_stall.valid", 64'(vld0), 64'h0);
        chk("flush_stall.we",    64'(we0),  64'h0);
        Stall = 1'b0; Flush = 1'b0; tick();
        chk0("post_flush", 32'h0000_0044, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);

        // r0 never written, invalid slot and non-writing instruction
        Dest_Reg = 5'd0; tick();
        chk0("r0", 32'h0000_0044, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        Dest_Reg = 5'd3; In_Valid = 1'b0; tick();
        chk0("invalid", 32'h0000_0044, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        In_Valid = 1'b1; RegWrite = 1'b0; tick();
        chk0("no_regwrite", 32'h0000_0044, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        RegWrite = 1'b1;

        // Out-of-range select on the 3-source build
        Dest_Reg = 5'd5; wb1 = 2'd3; tick();
        chk("oob.data", 64'(data1), 64'h0);
        chk("oob.serr", 64'(serr1), 64'h1);
        chk("oob.we",   64'(we1),   64'h0);
        wb1 = 2'd0; tick();
        chk("oob_clear.data", 64'(data1), 64'h7);
        chk("oob_clear.serr", 64'(serr1), 64'h0);
        chk("oob_clear.we",   64'(we1),   64'h1);

        // 64-bit build
        wb2 = 2'd1; Load_Size = 2'b00; Load_Unsigned = 1'b0; off2 = 3'd7; tick();
        chk("w64_lb_s_o7", 64'(data2), 64'hFFFF_FFFF_FFFF_FF80);
        Load_Size = 2'b01; Load_Unsigned = 1'b1; off2 = 3'd6; tick();
        chk("w64_lh_u_o6", 64'(data2), 64'h0000_0000_0000_8000);
        Load_Size = 2'b10; off2 = 3'd4; tick();
        chk("w64_lw_o4.aerr", 64'(aerr2), 64'h1);
        chk("w64_lw_o4.we",   64'(we2),   64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
